// File: rtl/bitstream_ram_writer.sv
// bitstream_ram_writer: packs an incoming byte stream MSB-first into 16-bit
// words and writes them into the decoder's bitstream RAM as a circular buffer.
// Words still unread by the decoder, plus a small guard window, are never
// overwritten.
module bitstream_ram_writer #(
  parameter int ADDR_W = 17,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              stream_end,
  output logic              BitStream_ram_wen,
  output logic [ADDR_W-1:0] BitStream_ram_waddr,
  output logic [15:0]       BitStream_ram_wdata,
  input  logic              BitStream_ram_ren,
  input  logic [ADDR_W-1:0] BitStream_ram_addr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              flush_done
);

  typedef enum logic [1:0] {EMPTY, HALF, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_mark_q, rd_mark_d;
  logic              flush_done_q, flush_done_d;

  logic [ADDR_W-1:0] free;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;

  // A word registered but not yet issued still occupies a slot, so the
  // pending strobe is subtracted alongside the write pointer.
  assign free       = rd_mark_q - wr_ptr_q - ADDR_W'(wen_q) - ADDR_W'(1);
  assign byte_ready = (state_q != FLUSH) && (free > ADDR_W'(GUARD));
  assign accept     = byte_valid && byte_ready;
  // Address the next registered word lands on, including any in-flight write.
  assign next_addr  = wr_ptr_q + ADDR_W'(wen_q);

  // Next-state, word packing, pointer advance and read-mark tracking.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    flush_done_d = 1'b0;
    wr_ptr_d     = next_addr;
    rd_mark_d    = BitStream_ram_ren ? rd_mark_q : BitStream_ram_addr;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          hi_d    = byte_data;
          state_d = stream_end ? FLUSH : HALF;
        end
      end
      HALF: begin
        if (accept) begin
          wen_d        = 1'b1;
          waddr_d      = next_addr;
          wdata_d      = {hi_q, byte_data};
          flush_done_d = stream_end;
          state_d      = EMPTY;
        end
      end
      FLUSH: begin
        wen_d        = 1'b1;
        waddr_d      = next_addr;
        wdata_d      = {hi_q, 8'h00};
        flush_done_d = 1'b1;
        state_d      = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers; reset drops any held byte and cancels a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      hi_q         <= 8'h00;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 16'h0000;
      wr_ptr_q     <= '0;
      rd_mark_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_mark_q    <= rd_mark_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign BitStream_ram_wen   = wen_q;
  assign BitStream_ram_waddr = waddr_q;
  assign BitStream_ram_wdata = wdata_q;
  assign wr_ptr              = wr_ptr_q;
  assign flush_done          = flush_done_q;

endmodule

// File: tb/tb_bitstream_ram_writer.sv
// Bench for bitstream_ram_writer: a small address space keeps full/wrap
// scenarios short. A stream-level model (expected word queue with due cycles,
// word counters, last read mark) is compared against the DUT every cycle.
module tb_bitstream_ram_writer;
  localparam int AW    = 8;
  localparam int GUARD = 4;

  logic          clk, reset;
  logic          byte_valid, byte_ready, stream_end;
  logic [7:0]    byte_data;
  logic          wen, ren, flush_done;
  logic [AW-1:0] waddr, raddr, wr_ptr;
  logic [15:0]   wdata;

  bitstream_ram_writer #(.ADDR_W(AW), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .stream_end(stream_end),
    .BitStream_ram_wen(wen), .BitStream_ram_waddr(waddr), .BitStream_ram_wdata(wdata),
    .BitStream_ram_ren(ren), .BitStream_ram_addr(raddr),
    .wr_ptr(wr_ptr), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {int due; logic [AW-1:0] addr; logic [15:0] data; logic fl;} exp_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [15:0] data; logic fl;} wr_t;

  exp_t          q[$];
  wr_t           wlog[$];
  int            cyc = 0;
  int            rdy_low = 0;
  bit            started = 0;
  logic [AW-1:0] m_rdmark, m_pushed, m_wrptr, m_last_addr, free_m;
  logic [15:0]   m_last_data;
  logic [7:0]    m_hi;
  bit            m_have_hi, m_flush, exp_rdy, exp_wen, exp_fl;

  // Model: occupancy = words committed so far; writes appear one cycle after
  // the completing byte, two cycles after an odd final byte.
  always @(negedge clk) begin
    cyc++;
    if (started) begin
      free_m  = m_rdmark - m_pushed - AW'(1);
      exp_rdy = !m_flush && (free_m > AW'(GUARD));
      exp_wen = (q.size() > 0) && (q[0].due == cyc);
      exp_fl  = 1'b0;
      if (exp_wen) begin
        m_last_addr = q[0].addr;
        m_last_data = q[0].data;
        exp_fl      = q[0].fl;
      end
      chk("byte_ready", 32'(byte_ready), 32'(exp_rdy));
      chk("wen", 32'(wen), 32'(exp_wen));
      chk("waddr", 32'(waddr), 32'(m_last_addr));
      chk("wdata", 32'(wdata), 32'(m_last_data));
      chk("flush_done", 32'(flush_done), 32'(exp_fl));
      chk("wr_ptr", 32'(wr_ptr), 32'(m_wrptr));
      if (exp_wen) begin
        void'(q.pop_front());
        m_wrptr = m_wrptr + AW'(1);
      end
      if (wen) wlog.push_back('{cyc, waddr, wdata, flush_done});
      if (!byte_ready) rdy_low++;
    end
    if (reset) begin
      q.delete();
      m_rdmark = '0; m_pushed = '0; m_wrptr = '0;
      m_last_addr = '0; m_last_data = '0;
      m_hi = '0; m_have_hi = 0; m_flush = 0;
      started = 1;
    end else if (started) begin
      if (!ren) m_rdmark = raddr;
      if (m_flush) m_flush = 0;
      else if (byte_valid && exp_rdy) begin
        if (!m_have_hi) begin
          if (stream_end) begin
            q.push_back('{cyc + 2, m_pushed, {byte_data, 8'h00}, 1'b1});
            m_pushed = m_pushed + AW'(1);
            m_flush  = 1;
          end else begin
            m_hi = byte_data; m_have_hi = 1;
          end
        end else begin
          q.push_back('{cyc + 1, m_pushed, {m_hi, byte_data}, stream_end});
          m_pushed  = m_pushed + AW'(1);
          m_have_hi = 0;
        end
      end
    end
  end

  task automatic rand_rd();
    ren = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0, 1:    raddr = AW'($urandom);
      2:       raddr = wr_ptr + AW'($urandom_range(0, 8));
      default: ;
    endcase
  endtask

  // Offer one byte; ok reports whether it was taken within tmo cycles.
  task automatic send_byte(input logic [7:0] b, input logic e, input int tmo,
                           input bit rr, output bit ok);
    byte_valid = 1'b1; byte_data = b; stream_end = e; ok = 0;
    for (int i = 0; i < tmo && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) ok = 1;
      @(posedge clk); #1;
      if (rr) rand_rd();
    end
    byte_valid = 1'b0; stream_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; ren = 1'b1; byte_valid = 1'b0; stream_end = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    wlog.delete();
  endtask

  task automatic send_list(input logic [7:0] b[$], input int last_end);
    bit ok;
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], 1'(i == last_end), 20, 0, ok);
      if (!ok) chk("send_timeout", 0, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    int            stalls, disc, gaps, above;
    bit            wrapped;
    logic [AW-1:0] nxt;
    reset = 1'b1; byte_valid = 1'b0; byte_data = '0; stream_end = 1'b0;
    ren = 1'b1; raddr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 1);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    chk("rst_flush", 32'(flush_done), 0);
    @(posedge clk); #1;
    wlog.delete();

    // basic packing
    send_list('{8'h00, 8'h00, 8'h01, 8'h67}, -1);
    idle(3);
    chk("basic_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("basic_a0", 32'(wlog[0].addr), 0);
      chk("basic_d0", 32'(wlog[0].data), 32'h0000);
      chk("basic_a1", 32'(wlog[1].addr), 1);
      chk("basic_d1", 32'(wlog[1].data), 32'h0167);
      chk("basic_gap", wlog[1].cyc - wlog[0].cyc, 2);
    end
    chk("basic_wr_ptr", 32'(wr_ptr), 2);

    // odd-length end
    wlog.delete(); rdy_low = 0;
    send_list('{8'hAB, 8'hCD, 8'hEF}, 2);
    idle(4);
    chk("odd_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("odd_d0", 32'(wlog[0].data), 32'hABCD);
      chk("odd_f0", 32'(wlog[0].fl), 0);
      chk("odd_d1", 32'(wlog[1].data), 32'hEF00);
      chk("odd_f1", 32'(wlog[1].fl), 1);
    end
    chk("odd_rdy_low", rdy_low, 1);

    // reset mid-word
    do_reset();
    send_byte(8'h12, 0, 20, 0, ok);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    idle(2);
    chk("rstmid_nwr", wlog.size(), 0);
    chk("rstmid_wr_ptr", 32'(wr_ptr), 0);
    send_list('{8'h34, 8'h56}, -1);
    idle(3);
    chk("rstmid_nwr2", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("rstmid_a", 32'(wlog[0].addr), 0);
      chk("rstmid_d", 32'(wlog[0].data), 32'h3456);
    end

    // read mark and word completion in the same cycle: 6-0-1(pending)-1 = 4
    do_reset();
    send_byte(8'h11, 0, 20, 0, ok);
    ren = 1'b0; raddr = AW'(6);
    send_byte(8'h22, 0, 20, 0, ok);
    ren = 1'b1;
    @(negedge clk); chk("sim_rdy_a", 32'(byte_ready), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("sim_rdy_b", 32'(byte_ready), 0);
    chk("sim_wr_ptr", 32'(wr_ptr), 1);
    @(posedge clk); #1 ren = 1'b0; raddr = '0;
    @(posedge clk); #1 ren = 1'b1;
    @(negedge clk); chk("sim_rdy_c", 32'(byte_ready), 1);
    @(posedge clk); #1;

    // full / guard: decoder idle at mark 0
    do_reset();
    for (int i = 0; i < 600; i++) begin
      send_byte(8'($urandom), 0, 3, 0, ok);
      if (!ok) break;
    end
    @(negedge clk);
    chk("guard_rdy", 32'(byte_ready), 0);
    chk("guard_wr_ptr", 32'(wr_ptr), (1 << AW) - 5);
    above = 0;
    foreach (wlog[i]) if (32'(wlog[i].addr) >= (1 << AW) - 5) above++;
    chk("guard_no_overwrite", above, 0);
    @(posedge clk); #1 ren = 1'b0; raddr = AW'(8'h40);
    @(posedge clk); #1 ren = 1'b1;
    @(negedge clk); chk("guard_release", 32'(byte_ready), 1);
    @(posedge clk); #1;

    // wrap with the decoder tracking 8 words behind
    do_reset();
    stalls = 0;
    for (int i = 0; i < (1 << (AW + 1)) + 4; i++) begin
      ren = 1'b0; raddr = wr_ptr - AW'(8);
      send_byte(8'($urandom), 0, 1, 0, ok);
      if (!ok) stalls++;
    end
    ren = 1'b1;
    idle(4);
    disc = 0; gaps = 0; wrapped = 0;
    for (int i = 1; i < wlog.size(); i++) begin
      nxt = wlog[i-1].addr + AW'(1);
      if (wlog[i].addr != nxt) disc++;
      if (wlog[i].cyc - wlog[i-1].cyc != 2) gaps++;
      if (wlog[i-1].addr == '1 && wlog[i].addr == '0) wrapped = 1;
    end
    chk("wrap_stalls", stalls, 0);
    chk("wrap_nwr", wlog.size(), (1 << AW) + 2);
    chk("wrap_addr_seq", disc, 0);
    chk("wrap_gaps", gaps, 0);
    chk("wrap_seen", 32'(wrapped), 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; rand_rd(); end
      send_byte(8'($urandom), 1'($urandom_range(0, 7) == 0), 200, 1, ok);
      if (!ok) chk("rand_timeout", 0, 1);
    end
    ren = 1'b1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
